// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Holds the loader state encoding and the stream/word widths.
package prog_loader_pkg;

  localparam int BYTE_W    = 8;
  localparam int WORD_W    = 32;
  localparam int HDR_LEN_W = 16;

  typedef enum logic [2:0] {
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_e;

endpackage

// File: rtl/prog_loader_word_packer.sv
// Packs bytes MSB-first into a 32-bit word; word_full flags the 4th byte
// in the same cycle it is shifted in, so the caller can branch on it.
module word_packer
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [1:0]        cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (shift_en) begin
      word_d = {word_q[WORD_W-BYTE_W-1:0], byte_in};
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word      = word_q;
  assign word_full = shift_en && (cnt_q == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses a length-prefixed byte stream into instruction memory,
// verifies an XOR checksum, then releases the core via core_run.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int MEM_WORDS = 64,
  parameter int LEN_W     = HDR_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [31:0]       im_addr,
  output logic [WORD_W-1:0] im_wdata,
  output logic              core_run,
  output logic              busy,
  output logic              err
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [BYTE_W-1:0]  chk_q, chk_d;
  logic [31:0]        addr_q, addr_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d;

  logic               hs;
  logic               shift_en;
  logic [WORD_W-1:0]  word;
  logic               word_full;
  logic [31:0]        wr_addr;

  word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (shift_en),
    .byte_in   (byte_data),
    .word      (word),
    .word_full (word_full)
  );

  assign byte_ready = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                      (state_q == ST_DATA)   || (state_q == ST_CHK);
  assign hs         = byte_valid && byte_ready;
  assign wr_addr    = 32'(idx_q) << 2;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    chk_d    = chk_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    shift_en = 1'b0;
    case (state_q)
      ST_LEN_HI: begin
        if (hs) begin
          len_d   = LEN_W'(byte_data);
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (hs) begin
          len_d = {len_q[LEN_W-BYTE_W-1:0], byte_data};
          if (len_d > LEN_W'(MEM_WORDS))
            state_d = ST_ERR;
          else if (len_d == '0)
            state_d = ST_CHK;
          else
            state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (hs) begin
          shift_en = 1'b1;
          chk_d    = chk_q ^ byte_data;
          if (word_full)
            state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // Latch what is written so the memory port holds it afterwards.
        addr_d  = wr_addr;
        wdata_d = word;
        idx_d   = idx_q + LEN_W'(1);
        state_d = (idx_d == len_q) ? ST_CHK : ST_DATA;
      end
      ST_CHK: begin
        if (hs)
          state_d = (byte_data == chk_q) ? ST_DONE : ST_ERR;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LEN_HI;
      len_q   <= '0;
      idx_q   <= '0;
      chk_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      chk_q   <= chk_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign im_we    = (state_q == ST_WRITE);
  assign im_addr  = im_we ? wr_addr : addr_q;
  assign im_wdata = im_we ? word : wdata_q;
  assign core_run = (state_q == ST_DONE);
  assign err      = (state_q == ST_ERR);
  assign busy     = (state_q != ST_DONE) && (state_q != ST_ERR);

endmodule
